multicycle_main_control: RTL and testbench
==========================================

Name: multicycle_main_control

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Sits directly upstream of the ALU control decoder and drives its 2-bit ALU operation input.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Produces every datapath enable and mux select from a registered state and the opcode held in the instruction register.

Parameters:
- STATE_W, 4, width of state register and of the state debug output.
- OP_RTYPE, 6'b000000, opcode of R-type instructions.
- OP_LW, 6'b100011, opcode of load word.
- OP_SW, 6'b101011, opcode of store word.
- OP_BEQ, 6'b000100, opcode of branch equal.
- OP_J, 6'b000010, opcode of jump.
- OP_ADDI, 6'b001000, opcode of add immediate.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- opcode  input  6  instruction bits [31:26] from the instruction register.
- mem_ready  input  1  memory has completed the current read/write this cycle.
- PCWrite  output  1  unconditional PC load.
- PCWriteCond  output  1  PC load qualified by ALU zero.
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  output  1  memory read strobe.
- MemWrite  output  1  memory write strobe.
- MemtoReg  output  1  register write data select: 1 = MDR.
- IRWrite  output  1  instruction register load.
- PCSource  output  2  PC select: 00 = ALU, 01 = ALUOut, 10 = jump target.
- ALUOp  output  2  ALU operation to the ALU control decoder: 00 = add, 01 = subtract, 10 = funct field.
- ALUSrcA  output  1  ALU operand A select: 0 = PC, 1 = A.
- ALUSrcB  output  2  ALU operand B select: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = shifted sign-extended immediate.
- RegWrite  output  1  register file write enable.
- RegDst  output  1  destination register select: 1 = rd, 0 = rt.
- illegal_op  output  1  one-cycle flag for an unsupported opcode.
- state  output  STATE_W  current state (debug).

Behaviour:
- State is held in a STATE_W-bit register and updated on the clk rising edge.
- reset asserted, at any time and in any state: state goes to FETCH (0) immediately. Any in-flight instruction is abandoned and no further writes occur.
- Outputs are decoded combinationally from state, plus mem_ready in FETCH and opcode in DECODE.
- Any output not listed for a state is 0.
- Output values during reset are the FETCH values.
- FETCH (0):
  - MemRead=1, ALUSrcB=01, ALUOp=00, PCSource=00, IorD=0.
  - IRWrite=PCWrite=mem_ready.
  - Next state: DECODE if mem_ready, else stay in FETCH.
- DECODE (1):
  - ALUSrcB=11, ALUOp=00 (branch target precompute).
  - Next state by opcode: LW/SW -> MEMADR; RTYPE -> EXECUTE; BEQ -> BRANCH; J -> JUMP; ADDI -> ADDIEX.
  - Any other opcode -> FETCH with illegal_op=1 for this cycle only, and no write strobes.
- MEMADR (2): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: LW -> MEMRD, otherwise -> MEMWR.
- MEMRD (3): MemRead=1, IorD=1. Hold until mem_ready, then -> MEMWB.
- MEMWB (4): RegWrite=1, MemtoReg=1, RegDst=0 -> FETCH.
- MEMWR (5): MemWrite=1, IorD=1. Hold until mem_ready, then -> FETCH.
- EXECUTE (6): ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> ALUWB.
- ALUWB (7): RegWrite=1, RegDst=1, MemtoReg=0 -> FETCH.
- BRANCH (8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01 -> FETCH.
- JUMP (9): PCWrite=1, PCSource=10 -> FETCH.
- ADDIEX (10): ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> ADDIWB.
- ADDIWB (11): RegWrite=1, RegDst=0, MemtoReg=0 -> FETCH.
- Unused encodings 12-15: all outputs 0, next state FETCH (recovery).
- ALUOp=11 is never driven.
- Latency with mem_ready constantly 1:
  - R-type and ADDI: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ and J: 3 cycles.
- Each cycle mem_ready is low in FETCH, MEMRD or MEMWR adds exactly one cycle.
- opcode may change only while in FETCH. It is sampled in DECODE and MEMADR.

Test Plan:
- Assert reset mid-MEMRD with mem_ready=0 -> state=0 asynchronously (before the next clk edge), MemRead=1, IorD=0, RegWrite=0. After release and mem_ready=1, DECODE follows on the next edge.
- mem_ready=1, opcode=000000 -> states 0,1,6,7,0. ALUOp=10 only in state 6. RegWrite=1 and RegDst=1 only in state 7.
- opcode=100011, mem_ready low for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0. MemtoReg=1 and RegWrite=1 in state 4.
- opcode=101011 -> states 0,1,2,5,0. MemWrite=1 and IorD=1 in state 5 only. RegWrite is never asserted.
- opcode=000100 then 000010 -> BRANCH shows ALUOp=01, PCWriteCond=1, PCSource=01. JUMP shows PCWrite=1, PCSource=10.
- opcode=111111 -> illegal_op=1 for one cycle in DECODE, then FETCH. No MemWrite, RegWrite or PCWrite asserted.

Source files
------------

// File: rtl/multicycle_main_control.sv
// Main control FSM for the multicycle MIPS datapath: walks each instruction
// through fetch/decode/execute/memory/writeback and decodes every datapath control.
module multicycle_main_control #(
  parameter int          STATE_W  = 4,
  parameter logic [5:0]  OP_RTYPE = 6'b000000,
  parameter logic [5:0]  OP_LW    = 6'b100011,
  parameter logic [5:0]  OP_SW    = 6'b101011,
  parameter logic [5:0]  OP_BEQ   = 6'b000100,
  parameter logic [5:0]  OP_J     = 6'b000010,
  parameter logic [5:0]  OP_ADDI  = 6'b001000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemtoReg,
  output logic               IRWrite,
  output logic [1:0]         PCSource,
  output logic [1:0]         ALUOp,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               RegWrite,
  output logic               RegDst,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [STATE_W-1:0] {
    FETCH   = STATE_W'(0),
    DECODE  = STATE_W'(1),
    MEMADR  = STATE_W'(2),
    MEMRD   = STATE_W'(3),
    MEMWB   = STATE_W'(4),
    MEMWR   = STATE_W'(5),
    EXECUTE = STATE_W'(6),
    ALUWB   = STATE_W'(7),
    BRANCH  = STATE_W'(8),
    JUMP    = STATE_W'(9),
    ADDIEX  = STATE_W'(10),
    ADDIWB  = STATE_W'(11)
  } state_t;

  state_t state_q, state_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  assign state = state_q;

  // Memory handshake: the controller holds the access strobes steady in FETCH,
  // MEMRD and MEMWR; a cycle with mem_ready=1 completes the access and lets the
  // FSM advance, a cycle with mem_ready=0 repeats the same state.
  always_comb begin
    state_d     = FETCH;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    PCSource    = 2'b00;
    ALUOp       = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    illegal_op  = 1'b0;
    case (state_q)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        state_d = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        // Branch target is precomputed here while the opcode is decoded.
        ALUSrcB = 2'b11;
        if (opcode == OP_LW || opcode == OP_SW) state_d = MEMADR;
        else if (opcode == OP_RTYPE)            state_d = EXECUTE;
        else if (opcode == OP_BEQ)              state_d = BRANCH;
        else if (opcode == OP_J)                state_d = JUMP;
        else if (opcode == OP_ADDI)             state_d = ADDIEX;
        else begin
          illegal_op = 1'b1;
          state_d    = FETCH;
        end
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        state_d = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        state_d  = mem_ready ? FETCH : MEMWR;
      end
      EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_d = ALUWB;
      end
      ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = ADDIWB;
      end
      ADDIWB: begin
        RegWrite = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed bench for multicycle_main_control: a path-based model checked every
// cycle, plus literal state traces and reset-time expectations.
module tb_multicycle_main_control;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic [1:0] PCSource, ALUOp, ALUSrcB;
  logic       ALUSrcA, RegWrite, RegDst, illegal_op;
  logic [3:0] state;

  int checks = 0;
  int passes = 0;

  int exp_state = 0;
  int pq[$];

  multicycle_main_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .PCSource(PCSource), .ALUOp(ALUOp),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
    .RegDst(RegDst), .illegal_op(illegal_op), .state(state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    return op == OP_RTYPE || op == OP_LW || op == OP_SW ||
           op == OP_BEQ || op == OP_J || op == OP_ADDI;
  endfunction

  // Expected control word, written output-by-output from the state table.
  function automatic logic [16:0] exp_ctrl(input int st, input logic [5:0] op, input logic mr);
    logic       pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd, ill;
    logic [1:0] pcs, aop, asb;
    pcw  = (st == 0 && mr) || st == 9;
    pcwc = st == 8;
    iord = st == 3 || st == 5;
    mrd  = st == 0 || st == 3;
    mwr  = st == 5;
    m2r  = st == 4;
    irw  = st == 0 && mr;
    pcs  = (st == 8) ? 2'b01 : (st == 9) ? 2'b10 : 2'b00;
    aop  = (st == 6) ? 2'b10 : (st == 8) ? 2'b01 : 2'b00;
    asa  = st == 2 || st == 6 || st == 8 || st == 10;
    asb  = (st == 0) ? 2'b01 : (st == 1) ? 2'b11 : (st == 2 || st == 10) ? 2'b10 : 2'b00;
    rw   = st == 4 || st == 7 || st == 11;
    rd   = st == 7;
    ill  = st == 1 && !is_legal(op);
    return {pcw, pcwc, iord, mrd, mwr, m2r, irw, pcs, aop, asa, asb, rw, rd, ill};
  endfunction

  wire [16:0] act_ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                          IRWrite, PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite,
                          RegDst, illegal_op};

  // scoreboard: per-cycle compare, then advance the model along the instruction path
  always @(negedge clk) begin
    #2;
    if (reset) begin
      exp_state = 0;
      pq.delete();
    end
    chk("state", 32'(state), 32'(exp_state));
    chk("ctrl", 32'(act_ctrl), 32'(exp_ctrl(exp_state, opcode, mem_ready)));
    if (reset) exp_state = 0;
    else if (exp_state == 0) exp_state = mem_ready ? 1 : 0;
    else if (exp_state == 1) begin
      case (opcode)
        OP_RTYPE: pq = '{6, 7};
        OP_LW:    pq = '{2, 3, 4};
        OP_SW:    pq = '{2, 5};
        OP_BEQ:   pq = '{8};
        OP_J:     pq = '{9};
        OP_ADDI:  pq = '{10, 11};
        default:  pq.delete();
      endcase
      exp_state = (pq.size() > 0) ? pq.pop_front() : 0;
    end
    else if ((exp_state == 3 || exp_state == 5) && !mem_ready) exp_state = exp_state;
    else exp_state = (pq.size() > 0) ? pq.pop_front() : 0;
  end

  // driver: runs one instruction from FETCH back to FETCH, returns state trace
  task automatic run(input logic [5:0] op, input int fst, input int mst, output logic [31:0] tr);
    bit left = 0;
    bit done = 0;
    int st;
    tr = 0;
    opcode = op;
    for (int cyc = 0; cyc < 40; cyc++) begin
      st = exp_state;
      tr = (tr << 4) | 32'(st);
      if (left && st == 0) begin
        done = 1;
        break;
      end
      if (st != 0) left = 1;
      if (st == 0 && fst > 0) begin
        mem_ready = 1'b0;
        fst--;
      end else if ((st == 3 || st == 5) && mst > 0) begin
        mem_ready = 1'b0;
        mst--;
      end else mem_ready = 1'b1;
      @(negedge clk);
    end
    if (!done) begin
      checks++;
      $display("FAIL run_timeout: opcode %0h did not return to state 0 within 40 cycles", op);
    end
  endtask

  logic [31:0] tr;

  initial begin
    reset = 1'b1;
    opcode = OP_RTYPE;
    mem_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("reset_state", 32'(state), 32'h0);
    chk("reset_memread", 32'(MemRead), 32'h1);
    chk("reset_irwrite", 32'(IRWrite), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    run(OP_RTYPE, 0, 0, tr); chk("rtype_trace", tr, 32'h01670);
    run(OP_LW,    0, 2, tr); chk("lw_stall_trace", tr, 32'h01233340);
    run(OP_LW,    0, 0, tr); chk("lw_trace", tr, 32'h012340);
    run(OP_SW,    0, 0, tr); chk("sw_trace", tr, 32'h01250);
    run(OP_BEQ,   0, 0, tr); chk("beq_trace", tr, 32'h0180);
    run(OP_J,     0, 0, tr); chk("j_trace", tr, 32'h0190);
    run(6'b111111, 0, 0, tr); chk("illegal_trace", tr, 32'h010);
    run(OP_ADDI,  0, 0, tr); chk("addi_trace", tr, 32'h01ab0);
    run(OP_RTYPE, 1, 0, tr); chk("rtype_fstall_trace", tr, 32'h001670);
    run(OP_SW,    0, 1, tr); chk("sw_stall_trace", tr, 32'h012550);

    // asynchronous reset in the middle of a stalled load
    opcode = OP_LW;
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk("memrd_reached", 32'(state), 32'h3);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_state", 32'(state), 32'h0);
    chk("async_reset_memread", 32'(MemRead), 32'h1);
    chk("async_reset_iord", 32'(IorD), 32'h0);
    chk("async_reset_regwrite", 32'(RegWrite), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("post_reset_decode", 32'(state), 32'h1);
    begin
      bit back = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (exp_state == 0) begin
          back = 1;
          break;
        end
      end
      if (!back) begin
        checks++;
        $display("FAIL drain_timeout: state %0d did not return to 0", exp_state);
      end
    end
    @(negedge clk);
    #3;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
